axi4_lite_arbiter_2x1: RTL and testbench

AXI4_LITE_ARBITER_2X1 -- requirements
Module: axi4_lite_arbiter_2x1

---
 rtl/axi4_lite_pkg.sv | 17 +
 rtl/axi4_lite_rr_arb_ch.sv | 83 ++++++++
 rtl/axi4_lite_arbiter_2x1.sv | 50 +++++
 tb/tb_axi4_lite_arbiter_2x1.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_lite_pkg.sv
// Shared definitions for the two-master AXI4-Lite arbiter: FSM encoding,
// one-hot grant constants and the default watchdog limit.
package axi4_lite_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'b00,
    StGrantM1 = 2'b01,
    StGrantM2 = 2'b10
  } arb_state_e;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_M1   = 2'b01;
  localparam logic [1:0] GNT_M2   = 2'b10;

  localparam int unsigned DEFAULT_TIMEOUT = 256;

endpackage

// File: rtl/axi4_lite_rr_arb_ch.sv
// One arbitration channel: round-robin between two masters, grant held until
// the channel's completion handshake or until the watchdog expires.
module axi4_lite_rr_arb_ch
  import axi4_lite_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input  logic       aclk,
  input  logic       aresetn,
  input  logic       req_m1_i,
  input  logic       req_m2_i,
  input  logic       done_valid_i,
  input  logic       done_ready_i,
  output logic [1:0] grant_o,
  output logic       timeout_o
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int unsigned LastVal = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CntW-1:0] CntLast = CntW'(LastVal);
  localparam logic [CntW-1:0] CntMax  = CntW'(TIMEOUT_CYCLES);

  arb_state_e      state_q;
  logic [1:0]      grant_q;
  logic            timeout_q;
  logic [CntW-1:0] cnt_q;
  logic            last_m1_q;  // set when m1 was the most recent owner
  logic            done;
  logic            expired;

  assign done    = done_valid_i & done_ready_i;
  assign expired = (TIMEOUT_CYCLES > 0) && (cnt_q == CntLast);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= StIdle;
      grant_q   <= GNT_NONE;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
      last_m1_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          cnt_q <= '0;
          // On contention m1 wins unless it owned the channel last.
          if (req_m1_i && (!req_m2_i || !last_m1_q)) begin
            state_q   <= StGrantM1;
            grant_q   <= GNT_M1;
            last_m1_q <= 1'b1;
          end else if (req_m2_i) begin
            state_q   <= StGrantM2;
            grant_q   <= GNT_M2;
            last_m1_q <= 1'b0;
          end
        end
        StGrantM1, StGrantM2: begin
          if (done) begin
            state_q <= StIdle;
            grant_q <= GNT_NONE;
            cnt_q   <= '0;
          end else if (expired) begin
            state_q   <= StIdle;
            grant_q   <= GNT_NONE;
            cnt_q     <= '0;
            timeout_q <= 1'b1;
          end else if (cnt_q != CntMax) begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        default: begin
          state_q <= StIdle;
          grant_q <= GNT_NONE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign grant_o   = grant_q;
  assign timeout_o = timeout_q;

endmodule

// File: rtl/axi4_lite_arbiter_2x1.sv
// Two-master AXI4-Lite arbiter: independent write (B-completed) and read
// (R-completed) channels, each with its own round-robin FSM and watchdog.
module axi4_lite_arbiter_2x1
  import axi4_lite_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input  logic       aclk,
  input  logic       aresetn,
  input  logic       awvalid_out_m1,
  input  logic       awvalid_out_m2,
  input  logic       bvalid_out_s,
  input  logic       bready_in_s,
  input  logic       arvalid_out_m1,
  input  logic       arvalid_out_m2,
  input  logic       rvalid_out_s,
  input  logic       rready_in_s,
  output logic [1:0] wr_grant,
  output logic [1:0] rd_grant,
  output logic       wr_timeout,
  output logic       rd_timeout
);

  axi4_lite_rr_arb_ch #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wr_arb (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .req_m1_i    (awvalid_out_m1),
    .req_m2_i    (awvalid_out_m2),
    .done_valid_i(bvalid_out_s),
    .done_ready_i(bready_in_s),
    .grant_o     (wr_grant),
    .timeout_o   (wr_timeout)
  );

  axi4_lite_rr_arb_ch #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rd_arb (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .req_m1_i    (arvalid_out_m1),
    .req_m2_i    (arvalid_out_m2),
    .done_valid_i(rvalid_out_s),
    .done_ready_i(rready_in_s),
    .grant_o     (rd_grant),
    .timeout_o   (rd_timeout)
  );

endmodule

// File: tb/tb_axi4_lite_arbiter_2x1.sv
// Bench for axi4_lite_arbiter_2x1: a default-timeout instance and a
// TIMEOUT_CYCLES=4 instance share stimulus; expectations flow through a queue.
module tb_axi4_lite_arbiter_2x1;

  localparam int unsigned SelWr  = 0;
  localparam int unsigned SelRd  = 1;
  localparam int unsigned SelWr4 = 2;
  localparam int unsigned SelRd4 = 3;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  logic aw_m1 = 1'b0, aw_m2 = 1'b0, bvalid = 1'b0, bready = 1'b0;
  logic ar_m1 = 1'b0, ar_m2 = 1'b0, rvalid = 1'b0, rready = 1'b0;
  logic [1:0] wr_grant, rd_grant, wr_grant4, rd_grant4;
  logic wr_timeout, rd_timeout, wr_timeout4, rd_timeout4;

  typedef struct {
    string       tag;
    int unsigned sel;
    logic [2:0]  val;  // {timeout, grant}
  } exp_t;

  exp_t sb_q[$];
  int unsigned n_total = 0;
  int unsigned n_bad = 0;

  always #5 aclk = ~aclk;

  axi4_lite_arbiter_2x1 dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .awvalid_out_m1(aw_m1),
    .awvalid_out_m2(aw_m2),
    .bvalid_out_s  (bvalid),
    .bready_in_s   (bready),
    .arvalid_out_m1(ar_m1),
    .arvalid_out_m2(ar_m2),
    .rvalid_out_s  (rvalid),
    .rready_in_s   (rready),
    .wr_grant      (wr_grant),
    .rd_grant      (rd_grant),
    .wr_timeout    (wr_timeout),
    .rd_timeout    (rd_timeout)
  );

  axi4_lite_arbiter_2x1 #(
    .TIMEOUT_CYCLES(4)
  ) dut4 (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .awvalid_out_m1(aw_m1),
    .awvalid_out_m2(aw_m2),
    .bvalid_out_s  (bvalid),
    .bready_in_s   (bready),
    .arvalid_out_m1(ar_m1),
    .arvalid_out_m2(ar_m2),
    .rvalid_out_s  (rvalid),
    .rready_in_s   (rready),
    .wr_grant      (wr_grant4),
    .rd_grant      (rd_grant4),
    .wr_timeout    (wr_timeout4),
    .rd_timeout    (rd_timeout4)
  );

  task automatic check_eq(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got {to,gnt}=%b want %b at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [2:0] observe(input int unsigned sel);
    case (sel)
      SelWr:   return {wr_timeout, wr_grant};
      SelRd:   return {rd_timeout, rd_grant};
      SelWr4:  return {wr_timeout4, wr_grant4};
      default: return {rd_timeout4, rd_grant4};
    endcase
  endfunction

  task automatic sb_push(input string tag, input int unsigned sel, input logic [2:0] val);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_eq(e.tag, observe(e.sel), e.val);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
    drain();
  endtask

  task automatic do_reset();
    @(negedge aclk);
    aresetn = 1'b0;
    #1;
    for (int s = 0; s < 4; s++) sb_push("reset", s, 3'b000);
    drain();
    @(negedge aclk);
    aresetn = 1'b1;
  endtask

  initial begin
    // Reset state, with no clock edge needed.
    #2;
    for (int s = 0; s < 4; s++) sb_push("reset_async", s, 3'b000);
    drain();
    do_reset();

    // Single write request, completion on cycle 5; dropped request keeps grant.
    aw_m1 = 1'b1;
    sb_push("wr_grant_m1", SelWr, 3'b001);
    sb_push("rd_idle", SelRd, 3'b000);
    step();
    aw_m1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sb_push("wr_hold_m1", SelWr, 3'b001);
      step();
    end
    bvalid = 1'b1;
    bready = 1'b1;
    sb_push("wr_done_m1", SelWr, 3'b000);
    step();
    bvalid = 1'b0;
    bready = 1'b0;

    // Handshake present while idle is ignored; grant then completes.
    aw_m2 = 1'b1;
    bvalid = 1'b1;
    bready = 1'b1;
    sb_push("wr_idle_hs_ignored", SelWr, 3'b010);
    step();
    aw_m2 = 1'b0;
    sb_push("wr_done_m2", SelWr, 3'b000);
    step();
    bvalid = 1'b0;
    bready = 1'b0;

    // Contended reads alternate: 01, 00, 10, 00, 01.
    ar_m1 = 1'b1;
    ar_m2 = 1'b1;
    sb_push("rd_rr_0", SelRd, 3'b001);
    step();
    rvalid = 1'b1;
    rready = 1'b1;
    sb_push("rd_rr_1", SelRd, 3'b000);
    sb_push("wr_quiet", SelWr, 3'b000);
    step();
    rvalid = 1'b0;
    rready = 1'b0;
    sb_push("rd_rr_2", SelRd, 3'b010);
    step();
    rvalid = 1'b1;
    rready = 1'b1;
    sb_push("rd_rr_3", SelRd, 3'b000);
    step();
    rvalid = 1'b0;
    rready = 1'b0;
    sb_push("rd_rr_4", SelRd, 3'b001);
    step();
    ar_m1 = 1'b0;
    ar_m2 = 1'b0;
    rvalid = 1'b1;
    rready = 1'b1;
    sb_push("rd_rr_end", SelRd, 3'b000);
    step();
    rvalid = 1'b0;
    rready = 1'b0;

    // Parallel write to m1 and read to m2, completing independently.
    aw_m1 = 1'b1;
    ar_m2 = 1'b1;
    sb_push("par_wr", SelWr, 3'b001);
    sb_push("par_rd", SelRd, 3'b010);
    step();
    aw_m1 = 1'b0;
    ar_m2 = 1'b0;
    bvalid = 1'b1;
    bready = 1'b1;
    sb_push("par_wr_done", SelWr, 3'b000);
    sb_push("par_rd_held", SelRd, 3'b010);
    step();
    bvalid = 1'b0;
    bready = 1'b0;
    rvalid = 1'b1;
    rready = 1'b1;
    sb_push("par_wr_idle", SelWr, 3'b000);
    sb_push("par_rd_done", SelRd, 3'b000);
    step();
    rvalid = 1'b0;
    rready = 1'b0;

    // Watchdog (limit 4): grant drops with a one-cycle pulse 4 cycles after grant.
    do_reset();
    aw_m1 = 1'b1;
    sb_push("to_grant", SelWr4, 3'b001);
    step();
    aw_m1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sb_push("to_hold", SelWr4, 3'b001);
      step();
    end
    sb_push("to_pulse", SelWr4, 3'b100);
    sb_push("to_rd_quiet", SelRd4, 3'b000);
    step();
    sb_push("to_pulse_end", SelWr4, 3'b000);
    step();

    // Completion on the 4th granted cycle beats the watchdog.
    aw_m2 = 1'b1;
    sb_push("tc_grant", SelWr4, 3'b010);
    step();
    aw_m2 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sb_push("tc_hold", SelWr4, 3'b010);
      step();
    end
    bvalid = 1'b1;
    bready = 1'b1;
    sb_push("tc_done_no_to", SelWr4, 3'b000);
    step();
    bvalid = 1'b0;
    bready = 1'b0;
    sb_push("tc_after", SelWr4, 3'b000);
    step();

    // Asynchronous reset mid-grant, then m1 wins the first contention.
    aw_m2 = 1'b1;
    sb_push("ar_grant_m2", SelWr, 3'b010);
    sb_push("ar_grant_m2_4", SelWr4, 3'b010);
    step();
    #2;
    aresetn = 1'b0;
    #1;
    sb_push("ar_async_clr", SelWr, 3'b000);
    sb_push("ar_async_clr_4", SelWr4, 3'b000);
    drain();
    aw_m1 = 1'b1;
    #1;
    aresetn = 1'b1;
    sb_push("ar_first_m1", SelWr, 3'b001);
    sb_push("ar_first_m1_4", SelWr4, 3'b001);
    step();
    aw_m1 = 1'b0;
    aw_m2 = 1'b0;
    bvalid = 1'b1;
    bready = 1'b1;
    sb_push("ar_done", SelWr, 3'b000);
    sb_push("ar_done_4", SelWr4, 3'b000);
    step();
    bvalid = 1'b0;
    bready = 1'b0;

    drain();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
